// File: rtl/uart_tx_trigger_if.sv
// ---------------------------------------------------------------------------
// uart_tx_trigger_if
//
// Handshake between the transmit-request front end and the UART transmitter.
//   tx_start : one-cycle pulse that starts a frame      (front end -> tx)
//   tx_data  : byte to send, stable until next request  (front end -> tx)
//   tx_busy  : high while the transmitter shifts a frame (tx -> front end)
//
// master : the request front end (uart_tx_trigger)
// slave  : the UART transmitter
// ---------------------------------------------------------------------------
interface uart_tx_trigger_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;

  modport master (output tx_start, output tx_data, input tx_busy);
  modport slave  (input tx_start, input tx_data, output tx_busy);
endinterface

// File: rtl/uart_tx_trigger.sv
// ---------------------------------------------------------------------------
// uart_tx_trigger
//
// Front end for the UART transmitter. Synchronises and debounces the raw
// Transmit button and mode switch, turns a button press (or, in auto-repeat
// mode, a held button) into exactly one tx_start pulse, captures the switch
// byte at request time and follows tx_busy so requests are neither lost nor
// doubled while a frame is in flight.
//
// Ports:
//   clk_in      system clock
//   rst         synchronous reset, active-high
//   btn_in      raw Transmit button (asynchronous)
//   switch_in   raw mode switch (asynchronous): 0 single-shot, 1 auto-repeat
//   data_in     byte to send; captured only when a request is accepted
//   tx_bus      master side of the transmitter handshake
//   btn_level   debounced button level
//   repeat_mode debounced switch level
//   tx_pending  high from request acceptance until the transfer is done
// ---------------------------------------------------------------------------
module uart_tx_trigger #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_CYCLES   = 5000000,
  parameter int unsigned BUSY_WAIT       = 4
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              btn_in,
  input  logic              switch_in,
  input  logic [7:0]        data_in,
  uart_tx_trigger_if.master tx_bus,
  output logic              btn_level,
  output logic              repeat_mode,
  output logic              tx_pending
);

  localparam logic [19:0]       DB_MAX   = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0]       RPT_MAX  = 24'(REPEAT_CYCLES - 1);
  localparam int unsigned       WAIT_W   = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(BUSY_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  // Input conditioning: index 0 is the button, index 1 the mode switch.
  logic [SYNC_STAGES-1:0] btn_sync;
  logic [SYNC_STAGES-1:0] sw_sync;
  logic [1:0]             synced;
  logic [1:0]             stable;
  logic [1:0][19:0]       db_cnt;

  // Request generation and FSM.
  logic        btn_level_d;
  logic        press_edge;
  logic        rpt_run;
  logic        repeat_hit;
  logic [23:0] rpt_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  state_t      state;
  state_t      next_state;
  logic        capture;
  logic        start_next;
  logic        wait_inc;
  logic        tx_start_q;
  logic [7:0]  tx_data_q;

  // -------------------------------------------------------------------------
  // Synchronisers. data_in is deliberately not synchronised: it is sampled
  // only when a request is accepted and the switches are quasi-static.
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      btn_sync <= '0;
      sw_sync  <= '0;
    end else begin
      btn_sync <= {btn_sync[SYNC_STAGES-2:0], btn_in};
      sw_sync  <= {sw_sync[SYNC_STAGES-2:0], switch_in};
    end
  end

  assign synced = {sw_sync[SYNC_STAGES-1], btn_sync[SYNC_STAGES-1]};

  // -------------------------------------------------------------------------
  // Debounce: a new level is accepted only after the synced input has
  // disagreed with the stable level for DEBOUNCE_CYCLES consecutive cycles.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst) begin
      stable <= '0;
      db_cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (synced[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_MAX) begin
          stable[i] <= synced[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 20'd1;
        end
      end
    end
  end

  assign btn_level   = stable[0];
  assign repeat_mode = stable[1];

  // -------------------------------------------------------------------------
  // Request sources. The repeat timer only advances while the FSM is idle,
  // so the interval is measured from the end of the previous transfer.
  // -------------------------------------------------------------------------
  assign press_edge = btn_level & ~btn_level_d;
  assign rpt_run    = btn_level & repeat_mode & (state == IDLE);
  assign repeat_hit = rpt_run & (rpt_cnt == RPT_MAX);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      btn_level_d <= 1'b0;
      rpt_cnt     <= '0;
    end else begin
      btn_level_d <= btn_level;
      if (!rpt_run || capture) begin
        rpt_cnt <= '0;
      end else begin
        rpt_cnt <= rpt_cnt + 24'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register plus registered handshake outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state      <= next_state;
      tx_start_q <= start_next;
      // Cleared whenever not counting, so it is zero on entry to WAIT_BUSY.
      wait_cnt   <= wait_inc ? wait_cnt + 1'b1 : '0;
      if (capture) begin
        tx_data_q <= data_in;
      end
    end
  end

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    start_next = 1'b0;
    wait_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        // A press edge and a repeat hit in the same cycle are one request.
        if (press_edge || repeat_hit) begin
          capture    = 1'b1;
          next_state = PEND;
        end
      end
      PEND: begin
        if (!tx_bus.tx_busy) begin
          start_next = 1'b1;
          next_state = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        // A transmitter that never raises busy must not hang the front end.
        if (tx_bus.tx_busy) begin
          next_state = WAIT_DONE;
        end else if (wait_cnt == WAIT_MAX) begin
          next_state = IDLE;
        end else begin
          wait_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_bus.tx_busy) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign tx_bus.tx_start = tx_start_q;
  assign tx_bus.tx_data  = tx_data_q;
  assign tx_pending      = (state != IDLE);

endmodule

// File: doc/uart_tx_trigger.md
Name: uart_tx_trigger

Overview:
- Upstream front end for the UART transmitter: turns the raw Transmit push button and the Transmit mode switch into clean, single-cycle transmit requests.
- Synchronises and debounces both inputs and captures the 8-bit switch data at request time.
- Issues a one-cycle tx_start to the transmitter, then tracks its busy flag so no request is lost or doubled. With the switch set, holding the button auto-repeats transmissions at a fixed interval.

Parameters:
- SYNC_STAGES, 2: flip-flop stages in each input synchroniser (min 2).
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a new level (10 ms at 50 MHz).
- REPEAT_CYCLES, 5000000: auto-repeat interval in cycles, counted while IDLE with the button held.
- BUSY_WAIT, 4: cycles to wait for tx_busy to rise after tx_start before treating the transfer as done.

Ports:
- clk_in  input  1  system clock
- rst  input  1  synchronous reset, active-high
- btn_in  input  1  raw Transmit push button, asynchronous, active-high
- switch_in  input  1  raw mode switch, asynchronous; 0 = single-shot, 1 = auto-repeat
- data_in  input  8  byte to send, from the switches
- tx_busy  input  1  transmitter busy; high while a frame is shifting out
- tx_start  output  1  one-cycle pulse that starts the transmitter
- tx_data  output  8  byte captured at request; held stable until the next request
- btn_level  output  1  debounced button level
- repeat_mode  output  1  debounced switch level
- tx_pending  output  1  high in PEND, WAIT_BUSY and WAIT_DONE

Behaviour:
- Reset: every register clears on a clk_in edge with rst=1, including synchronisers, counters and the FSM (goes to IDLE). All outputs read 0 the cycle after. Reset mid-transfer abandons it: no tx_start afterwards until a fresh press.
- Synchroniser: SYNC_STAGES flops per input. data_in is not synchronised; it is captured only on a request and is quasi-static by definition.
- Debounce, per input:
  - A 20-bit counter clears whenever the synced value equals the stable value.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, the stable value takes the synced value and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
- Request sources:
  - press_edge = btn_level rising; it lasts 1 cycle.
  - repeat_hit: a 24-bit counter runs only while btn_level=1, repeat_mode=1 and state=IDLE. It clears otherwise and on every request. repeat_hit fires when the counter reaches REPEAT_CYCLES-1.
- FSM:
  - IDLE: on press_edge or repeat_hit, latch tx_data<=data_in and go to PEND.
  - PEND: if tx_busy=0, assert tx_start for this one cycle and go to WAIT_BUSY. Otherwise stay in PEND.
  - WAIT_BUSY: if tx_busy=1, go to WAIT_DONE. If BUSY_WAIT cycles pass without tx_busy, go to IDLE.
  - WAIT_DONE: when tx_busy=0, go to IDLE.
- Latency: from btn_level rising with tx_busy=0, tx_start asserts exactly 2 cycles later (IDLE->PEND, then the PEND cycle).
- Requests outside IDLE are dropped, never queued. Exactly one tx_start per accepted request.
- Simultaneous press_edge and repeat_hit: count as one request.
- Switch changes mid-transfer: the current transfer completes. The new mode applies from the next IDLE.
- Release during PEND: the pending transfer still completes.
- tx_start never asserts while tx_busy=1, and never on two consecutive cycles.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20, BUSY_WAIT=4, SYNC_STAGES=2):
1. rst high 3 cycles, then low; all inputs 0. Required: tx_start, tx_data, btn_level, tx_pending all 0.
2. data_in=0xA5, switch 0, btn_in held high, transmitter model raises tx_busy 1 cycle after tx_start for 10 cycles. Required: btn_level rises 6 cycles after btn_in, then exactly one tx_start 2 cycles later, tx_data=0xA5, tx_pending falls when tx_busy falls, and no further tx_start while held.
3. btn_in high for 3 cycles, then low. Required: btn_level stays 0 and no tx_start.
4. Switch 1, button held 200 cycles, data_in changed 0x11->0x22 mid-hold. Required: first tx_start sends 0x11; later tx_starts repeat about every 20 IDLE cycles with tx_data=0x22 after the change; none while tx_busy=1.
5. tx_busy held 1 before the press. Required: FSM waits in PEND with tx_start 0; tx_start asserts the first cycle after tx_busy drops.
6. Transmitter model never raises tx_busy. Required: one tx_start, return to IDLE 4 cycles later, tx_pending 0. Then assert rst during WAIT_DONE in a separate run: required state IDLE and no tx_start afterwards.
